// File: rtl/gnt_decoder.sv
// Grant-bundle consumer: turns AMOUNT_M cumulative grant masks into one beat per
// granted requester (binary + one-hot), ascending position order, last flag on final beat.

module gnt_dec_slot #(
  parameter int WIDTH_N   = 10,
  parameter int WIDTH_IDX = 4
) (
  input  logic [WIDTH_N-1:0]   gnt,
  output logic [WIDTH_N-1:0]   onehot,
  output logic [WIDTH_IDX-1:0] idx,
  output logic                 nz
);
  // Cumulative mask: the lowest set bit marks the granted requester.
  assign onehot = gnt & ~(gnt << 1);
  assign nz     = |gnt;

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH_N; i++)
      if (onehot[i]) idx = idx | WIDTH_IDX'(i);
  end
endmodule

module gnt_decoder #(
  parameter  int WIDTH_N   = 10,
  parameter  int AMOUNT_M  = 2,
  localparam int WIDTH_IDX = (WIDTH_N > 1) ? $clog2(WIDTH_N) : 1
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [AMOUNT_M-1:0][WIDTH_N-1:0]  gnt_i,
  input  logic                              gnt_vld_i,
  output logic                              gnt_rdy_o,
  output logic [WIDTH_IDX-1:0]              idx_o,
  output logic [WIDTH_N-1:0]                onehot_o,
  output logic                              idx_last_o,
  output logic                              idx_vld_o,
  input  logic                              idx_rdy_i
);
  localparam int PTR_W = (AMOUNT_M > 1) ? $clog2(AMOUNT_M) : 1;
  localparam int CNT_W = $clog2(AMOUNT_M + 1);

  typedef enum logic {IDLE, EMIT} state_t;

  logic [AMOUNT_M-1:0][WIDTH_N-1:0]   dec_oh, oh_q;
  logic [AMOUNT_M-1:0][WIDTH_IDX-1:0] dec_idx, idx_q;
  logic [AMOUNT_M-1:0]                dec_nz;
  logic [CNT_W-1:0]                   n, n_q;
  logic [PTR_W-1:0]                   ptr_q, ptr_d;
  state_t                             state_q, state_d;
  logic [WIDTH_N-1:0]                 sel_oh;
  logic [WIDTH_IDX-1:0]               sel_idx;
  logic                               emit, is_last, accept, beat, legal;

  for (genvar s = 0; s < AMOUNT_M; s++) begin : g_slot
    gnt_dec_slot #(.WIDTH_N(WIDTH_N), .WIDTH_IDX(WIDTH_IDX)) u_slot (
      .gnt    (gnt_i[s]),
      .onehot (dec_oh[s]),
      .idx    (dec_idx[s]),
      .nz     (dec_nz[s])
    );
  end

  always_comb begin
    n = '0;
    for (int s = 0; s < AMOUNT_M; s++) n = n + CNT_W'(dec_nz[s]);
  end

  // Beat ptr reads slot AMOUNT_M-1-ptr, i.e. lowest requester position first.
  always_comb begin
    sel_oh  = '0;
    sel_idx = '0;
    for (int s = 0; s < AMOUNT_M; s++)
      if (ptr_q == PTR_W'(AMOUNT_M - 1 - s)) begin
        sel_oh  = oh_q[s];
        sel_idx = idx_q[s];
      end
  end

  assign emit       = (state_q == EMIT);
  assign is_last    = (CNT_W'(ptr_q) + CNT_W'(1)) == n_q;
  assign idx_vld_o  = emit;
  assign idx_o      = emit ? sel_idx : '0;
  assign onehot_o   = emit ? sel_oh  : '0;
  assign idx_last_o = emit & is_last;
  assign gnt_rdy_o  = ~emit | (is_last & idx_rdy_i);
  assign accept     = gnt_vld_i & gnt_rdy_o;
  assign beat       = emit & idx_rdy_i;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (beat) begin
      if (is_last) state_d = IDLE;
      else         ptr_d   = ptr_q + PTR_W'(1);
    end
    if (accept) begin
      state_d = (n != '0) ? EMIT : IDLE;
      ptr_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      n_q     <= '0;
      oh_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (accept) begin
        n_q   <= n;
        oh_q  <= dec_oh;
        idx_q <= dec_idx;
      end
    end
  end

  // A legal bundle has every lower mask contained in the one above it.
  always_comb begin
    legal = 1'b1;
    for (int s = 0; s < AMOUNT_M - 1; s++)
      if ((gnt_i[s] & ~gnt_i[s+1]) != '0) legal = 1'b0;
  end

  a_legal: assert property (@(posedge clk) disable iff (!reset_n) gnt_vld_i |-> legal);
  a_out_hold: assert property (@(posedge clk) disable iff (!reset_n)
    idx_vld_o & ~idx_rdy_i |=> idx_vld_o & $stable(idx_o) & $stable(onehot_o) & $stable(idx_last_o));
  a_onehot: assert property (@(posedge clk) disable iff (!reset_n) idx_vld_o |-> $onehot(onehot_o));
  a_in_hold: assert property (@(posedge clk) disable iff (!reset_n)
    gnt_vld_i & ~gnt_rdy_o |=> gnt_vld_i & $stable(gnt_i));
endmodule

// File: tb/tb_gnt_decoder.sv
// Directed checks of gnt_decoder (M=2) plus a randomized stream check on an M=3 instance.

module tb_gnt_decoder;
  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0][9:0]  gnt = '0;
  logic             gnt_vld = 1'b0, gnt_rdy, idx_last, idx_vld, idx_rdy = 1'b1;
  logic [3:0]       idx;
  logic [9:0]       onehot;
  logic [16:0]      snap;

  logic [2:0][9:0]  r_gnt = '0;
  logic             r_vld = 1'b0, r_grdy, r_last, r_ivld, r_irdy = 1'b1;
  logic [3:0]       r_idx;
  logic [9:0]       r_oh;

  logic [4:0]       exp_q[$];
  int               n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  gnt_decoder #(.WIDTH_N(10), .AMOUNT_M(2)) dut (
    .clk(clk), .reset_n(reset_n), .gnt_i(gnt), .gnt_vld_i(gnt_vld), .gnt_rdy_o(gnt_rdy),
    .idx_o(idx), .onehot_o(onehot), .idx_last_o(idx_last), .idx_vld_o(idx_vld), .idx_rdy_i(idx_rdy)
  );

  gnt_decoder #(.WIDTH_N(10), .AMOUNT_M(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .gnt_i(r_gnt), .gnt_vld_i(r_vld), .gnt_rdy_o(r_grdy),
    .idx_o(r_idx), .onehot_o(r_oh), .idx_last_o(r_last), .idx_vld_o(r_ivld), .idx_rdy_i(r_irdy)
  );

  assign snap = {gnt_rdy, idx_vld, idx_last, idx, onehot};

  localparam logic [16:0] IDLE_S = {1'b1, 1'b0, 1'b0, 4'd0, 10'h000};
  localparam logic [16:0] S1_B0  = {1'b0, 1'b1, 1'b0, 4'd2, 10'h004};
  localparam logic [16:0] S1_B1  = {1'b1, 1'b1, 1'b1, 4'd5, 10'h020};

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_s1();
    gnt = {10'b1111111100, 10'b1111100000};
    gnt_vld = 1'b1;
    step();
    gnt_vld = 1'b0;
    gnt = '0;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    n_cmp++;
    if (snap[15:0] !== 16'h0) begin
      n_bad++; $display("FAIL reset_outputs got %h want 0000", snap[15:0]);
    end
    @(posedge clk); #1 reset_n = 1'b1;
    step();
    n_cmp++;
    if (snap !== IDLE_S) begin
      n_bad++; $display("FAIL reset_idle got %h want %h", snap, IDLE_S);
    end
  endtask

  task automatic test_two_grant();
    idx_rdy = 1'b1;
    send_s1();
    n_cmp++;
    if (snap !== S1_B0) begin n_bad++; $display("FAIL two_beat0 got %h want %h", snap, S1_B0); end
    step();
    n_cmp++;
    if (snap !== S1_B1) begin n_bad++; $display("FAIL two_beat1 got %h want %h", snap, S1_B1); end
    step();
    n_cmp++;
    if (snap !== IDLE_S) begin n_bad++; $display("FAIL two_done got %h want %h", snap, IDLE_S); end
  endtask

  task automatic test_single_zero();
    logic [16:0] e;
    e = {1'b1, 1'b1, 1'b1, 4'd7, 10'h080};
    gnt = {10'b1110000000, 10'b0};
    gnt_vld = 1'b1;
    step();
    gnt_vld = 1'b0; gnt = '0; #1;
    n_cmp++;
    if (snap !== e) begin n_bad++; $display("FAIL single_beat got %h want %h", snap, e); end
    step();
    n_cmp++;
    if (snap !== IDLE_S) begin n_bad++; $display("FAIL single_done got %h want %h", snap, IDLE_S); end
    gnt_vld = 1'b1; #1;
    n_cmp++;
    if (gnt_rdy !== 1'b1) begin n_bad++; $display("FAIL zero_rdy got %b want 1", gnt_rdy); end
    step();
    gnt_vld = 1'b0; #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (snap !== IDLE_S) begin n_bad++; $display("FAIL zero_nobeat got %h want %h", snap, IDLE_S); end
      step();
    end
  endtask

  task automatic test_backpressure();
    idx_rdy = 1'b0;
    send_s1();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (snap !== S1_B0) begin n_bad++; $display("FAIL bp_hold%0d got %h want %h", i, snap, S1_B0); end
      step();
    end
    idx_rdy = 1'b1; #1;
    n_cmp++;
    if (snap !== S1_B0) begin n_bad++; $display("FAIL bp_release got %h want %h", snap, S1_B0); end
    step();
    n_cmp++;
    if (snap !== S1_B1) begin n_bad++; $display("FAIL bp_beat1 got %h want %h", snap, S1_B1); end
    step();
    n_cmp++;
    if (snap !== IDLE_S) begin n_bad++; $display("FAIL bp_done got %h want %h", snap, IDLE_S); end
  endtask

  task automatic test_back_to_back();
    logic [16:0] e;
    e = {1'b1, 1'b1, 1'b1, 4'd9, 10'h200};
    idx_rdy = 1'b1;
    send_s1();
    step();
    gnt = {10'b1000000000, 10'b0};
    gnt_vld = 1'b1; #1;
    n_cmp++;
    if (snap !== S1_B1) begin n_bad++; $display("FAIL b2b_last got %h want %h", snap, S1_B1); end
    step();
    gnt_vld = 1'b0; gnt = '0; #1;
    n_cmp++;
    if (snap !== e) begin n_bad++; $display("FAIL b2b_next got %h want %h", snap, e); end
    step();
    n_cmp++;
    if (snap !== IDLE_S) begin n_bad++; $display("FAIL b2b_done got %h want %h", snap, IDLE_S); end
  endtask

  task automatic test_reset_mid();
    idx_rdy = 1'b1;
    send_s1();
    step();
    n_cmp++;
    if (snap !== S1_B1) begin n_bad++; $display("FAIL rst_pre got %h want %h", snap, S1_B1); end
    reset_n = 1'b0; #1;
    n_cmp++;
    if (snap[15:0] !== 16'h0) begin n_bad++; $display("FAIL rst_async got %h want 0000", snap[15:0]); end
    @(posedge clk); #1 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (snap !== IDLE_S) begin n_bad++; $display("FAIL rst_after%0d got %h want %h", i, snap, IDLE_S); end
    end
  endtask

  // Encoder reference: slot 2-r starts at the (r+1)-th set request bit.
  task automatic make_bundle(output logic [2:0][9:0] g);
    logic [9:0] req, m;
    int k, c;
    req = ($urandom_range(0, 7) == 0) ? 10'h000 : 10'($urandom_range(0, 1023));
    k = $countones(req);
    if (k > 3) k = 3;
    g = '0;
    c = 0;
    for (int p = 0; p < 10; p++)
      if (req[p] && c < 3) begin
        m = 10'h3FF << p;
        g[2-c] = m;
        exp_q.push_back({(c == k - 1), 4'(p)});
        c++;
      end
  endtask

  task automatic test_random();
    int acc = 0, cyc = 0;
    logic took;
    logic [4:0] e;
    logic [9:0] eo;
    make_bundle(r_gnt);
    r_vld = 1'b1;
    while ((acc < 1000 || exp_q.size() > 0) && cyc < 30000) begin
      r_irdy = 1'($urandom_range(0, 1));
      #1;
      if (r_ivld && r_irdy) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL rnd_extra got idx %0d want no beat", r_idx);
        end else begin
          e = exp_q.pop_front();
          eo = 10'd1 << e[3:0];
          if ({r_last, r_idx, r_oh} !== {e[4], e[3:0], eo}) begin
            n_bad++;
            $display("FAIL rnd_beat got last=%b idx=%0d oh=%h want last=%b idx=%0d oh=%h",
                     r_last, r_idx, r_oh, e[4], e[3:0], eo);
          end
        end
      end
      took = r_vld && r_grdy;
      step();
      cyc++;
      if (took) begin
        acc++;
        if (acc < 1000) make_bundle(r_gnt);
        else begin r_vld = 1'b0; r_gnt = '0; end
      end
    end
    n_cmp++;
    if (acc != 1000 || exp_q.size() != 0) begin
      n_bad++; $display("FAIL rnd_drain got acc=%0d pending=%0d want acc=1000 pending=0", acc, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_two_grant();
    test_single_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
